// File: rtl/requant_pack_pkg.sv
// Shared definitions for the requantise/pack stage.
// Provides the lane/width constants, the packed FIFO word type, and the
// per-lane helpers: round-half-up arithmetic shift, then int8 saturation
// with optional ReLU.
package requant_pack_pkg;

  localparam int LANES     = 4;
  localparam int IN_W      = 23;
  localparam int ACC_W     = 24;
  localparam int OUT_W     = 8;
  localparam int SAT_MAX   = 127;
  localparam int SAT_MIN   = -128;
  localparam int MAX_SHIFT = 22;
  localparam int WORD_W    = LANES * OUT_W;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } word_t;

  // Add half an LSB of the result, then shift arithmetically: rounds half toward +inf.
  // One extra bit of headroom keeps x + 2^21 from overflowing.
  function automatic logic signed [ACC_W-1:0] rq_round(input logic signed [IN_W-1:0] x,
                                                       input logic [4:0] s);
    logic signed [ACC_W-1:0] t;
    logic signed [ACC_W-1:0] half;
    t = $signed({x[IN_W-1], x});
    if (s != 5'd0) begin
      half = $signed(ACC_W'(1) << (s - 5'd1));
    end else begin
      half = '0;
    end
    t = t + half;
    return t >>> s;
  endfunction

  // Clamp to int8, then optionally zero negative results.
  function automatic logic [OUT_W-1:0] rq_sat(input logic signed [ACC_W-1:0] r,
                                              input logic relu);
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(SAT_MIN);
    logic [OUT_W-1:0] o;
    if (r > HI) begin
      o = 8'h7F;
    end else if (r < LO) begin
      o = 8'h80;
    end else begin
      o = r[OUT_W-1:0];
    end
    if (relu && o[OUT_W-1]) begin
      o = 8'h00;
    end else begin
      o = o;
    end
    return o;
  endfunction

endpackage

// File: rtl/requant_pack_fifo.sv
// rq_sync_fifo: first-word fall-through synchronous FIFO.
// Ports: clk/rstn (sync, active-low), wr_en_i/wr_data_i push side,
// rd_en_i pop request, rd_data_o head entry (valid when !empty_o),
// full_o/empty_o/count_o occupancy.
// A push while full is accepted only if a pop happens on the same edge;
// a pop while empty is ignored (no bypass path).
module rq_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_pop_s  = rd_en_i && !empty_o;
  assign do_push_s = wr_en_i && (!full_o || do_pop_s);

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/requant_pack.sv
// requant_pack: requantises four signed 23-bit lane sums to int8 and packs
// them into a 32-bit word buffered in a small output FIFO.
// Ports: clk/rstn (sync, active-low); vld_i + iIn0..iIn3 lane sums;
// iShift/iRelu_en config sampled with vld_i; iOvf_clr clears oOvf;
// iRdy/oVld/oData/oLast output stream; oOvf sticky drop flag.
// Pipeline: stage 1 round+shift, stage 2 saturate/ReLU/pack, then FIFO.
module requant_pack
  import requant_pack_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_WORDS = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   vld_i,
  input  logic signed [IN_W-1:0] iIn0,
  input  logic signed [IN_W-1:0] iIn1,
  input  logic signed [IN_W-1:0] iIn2,
  input  logic signed [IN_W-1:0] iIn3,
  input  logic [4:0]             iShift,
  input  logic                   iRelu_en,
  input  logic                   iOvf_clr,
  input  logic                   iRdy,
  output logic [WORD_W-1:0]      oData,
  output logic                   oLast,
  output logic                   oVld,
  output logic                   oOvf
);

  localparam int FC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [FC_W-1:0] LAST_CNT = FC_W'(FRAME_WORDS - 1);

  logic [4:0]                  shift_s;
  logic [LANES-1:0][ACC_W-1:0] s1_r_d, s1_r_q;
  logic                        s1_vld_q, s1_relu_q;
  word_t                       s2_word_d, s2_word_q;
  logic                        s2_vld_q;
  logic [FC_W-1:0]             frame_cnt_d, frame_cnt_q;
  word_t                       head_s;
  logic                        fifo_full_s, fifo_empty_s, pop_s, drop_s;
  logic                        ovf_d, ovf_q;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused_s;

  assign shift_s = (iShift > 5'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : iShift;

  // Stage-1 combinational rounding per lane.
  always_comb begin
    s1_r_d    = '0;
    s1_r_d[0] = rq_round(iIn0, shift_s);
    s1_r_d[1] = rq_round(iIn1, shift_s);
    s1_r_d[2] = rq_round(iIn2, shift_s);
    s1_r_d[3] = rq_round(iIn3, shift_s);
  end

  // Stage-2 combinational saturate/pack plus frame position of this word.
  always_comb begin
    s2_word_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s2_word_d.data[i*OUT_W +: OUT_W] = rq_sat($signed(s1_r_q[i]), s1_relu_q);
    end
    s2_word_d.last = (frame_cnt_q == LAST_CNT);
    if (s1_vld_q) begin
      frame_cnt_d = s2_word_d.last ? '0 : frame_cnt_q + FC_W'(1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Pipeline registers; the frame counter advances even for words later dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_vld_q    <= 1'b0;
      s1_relu_q   <= 1'b0;
      s1_r_q      <= '0;
      s2_vld_q    <= 1'b0;
      s2_word_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      s1_vld_q    <= vld_i;
      s2_vld_q    <= s1_vld_q;
      frame_cnt_q <= frame_cnt_d;
      if (vld_i) begin
        s1_r_q    <= s1_r_d;
        s1_relu_q <= iRelu_en;
      end
      if (s1_vld_q) begin
        s2_word_q <= s2_word_d;
      end
    end
  end

  assign pop_s  = oVld && iRdy;
  assign drop_s = s2_vld_q && fifo_full_s && !pop_s;

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (iOvf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  rq_sync_fifo #(
    .WIDTH($bits(word_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en_i  (s2_vld_q),
    .wr_data_i(s2_word_q),
    .rd_en_i  (pop_s),
    .rd_data_o(head_s),
    .full_o   (fifo_full_s),
    .empty_o  (fifo_empty_s),
    .count_o  (fifo_count_unused_s)
  );

  assign oVld  = !fifo_empty_s;
  assign oData = head_s.data;
  assign oLast = head_s.last;
  assign oOvf  = ovf_q;

endmodule

// File: tb/tb_requant_pack.sv
// Directed testbench for requant_pack (FIFO_DEPTH=4, FRAME_WORDS=3).
// Expected words are queued when a beat is driven and compared when the
// DUT hands the word over (oVld && iRdy), sampled on the falling edge.
module tb_requant_pack;

  localparam int FW = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        vld_i = 1'b0;
  logic [22:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [4:0]  shift = '0;
  logic        relu = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] o_data;
  logic        o_last, o_vld, o_ovf;

  int          n_checks = 0;
  int          n_pass = 0;
  int          fcnt = 0;
  logic [32:0] sb[$];
  logic        held_v = 1'b0;
  logic [32:0] held_w = '0;

  requant_pack #(.FIFO_DEPTH(4), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rstn(rstn), .vld_i(vld_i),
    .iIn0(in0), .iIn1(in1), .iIn2(in2), .iIn3(in3),
    .iShift(shift), .iRelu_en(relu), .iOvf_clr(ovf_clr), .iRdy(rdy),
    .oData(o_data), .oLast(o_last), .oVld(o_vld), .oOvf(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Reference lane: floor((x + half) / 2^s) computed by integer division.
  function automatic logic [7:0] m_lane(input int x, input int s, input bit r);
    int sc, d, t, q;
    sc = (s > 22) ? 22 : s;
    d  = 1 << sc;
    t  = x + ((sc > 0) ? d / 2 : 0);
    q  = t / d;
    if (t < 0 && q * d != t) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    if (r && q < 0) q = 0;
    return q[7:0];
  endfunction

  function automatic logic [31:0] m_word(input int a, input int b, input int c, input int d,
                                         input int s, input bit r);
    return {m_lane(d, s, r), m_lane(c, s, r), m_lane(b, s, r), m_lane(a, s, r)};
  endfunction

  // One clock cycle of stimulus; a valid beat advances the frame model and,
  // if keep is set, queues the expected word.
  task automatic step(input bit v, input bit keep, input int a, input int b, input int c,
                      input int d, input int s, input bit r, input bit rd,
                      input logic [31:0] exp_data);
    logic exp_last;
    vld_i = v; in0 = a[22:0]; in1 = b[22:0]; in2 = c[22:0]; in3 = d[22:0];
    shift = s[4:0]; relu = r; rdy = rd;
    if (v) begin
      exp_last = (fcnt == FW - 1);
      fcnt = exp_last ? 0 : fcnt + 1;
      if (keep) sb.push_back({exp_last, exp_data});
    end
    @(posedge clk); #1;
    vld_i = 1'b0;
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, rd, 32'h0);
  endtask

  task automatic drain();
    int n = 0;
    rdy = 1'b1;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_done", 64'(sb.size()), 64'd0);
    chk("drain_vld", 64'(o_vld), 64'd0);
  endtask

  // Output monitor: scoreboard compare on handover, stability while stalled.
  always @(negedge clk) begin
    if (!rstn) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_vld", 64'(o_vld), 64'd1);
        chk("hold_word", 64'({o_last, o_data}), 64'(held_w));
      end
      if (o_vld && rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", 64'({o_last, o_data}), 64'h1_0000_0000_dead);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          chk("data", 64'(o_data), 64'(e[31:0]));
          chk("last", 64'(o_last), 64'(e[32]));
        end
      end
      held_v = o_vld && !rdy;
      held_w = {o_last, o_data};
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 64'(o_vld), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_ovf", 64'(o_ovf), 64'd0);
    rstn = 1'b1;

    // Directed values, back-to-back at full rate
    step(1'b1, 1'b1, 1000, -1000, 100000, -100000, 4, 1'b0, 1'b1, 32'h807FC23F);
    step(1'b1, 1'b1, 1000, -1000, 100000, -100000, 4, 1'b1, 1'b1, 32'h007F003F);
    step(1'b1, 1'b1, 24, -24, 8, 7, 4, 1'b0, 1'b1, 32'h0001FF02);
    step(1'b1, 1'b1, 5, -5, 127, 128, 0, 1'b0, 1'b1, 32'h7F7FFB05);
    step(1'b1, 1'b1, -4194304, 4194303, 3, -3, 31, 1'b0, 1'b1,
         m_word(-4194304, 4194303, 3, -3, 31, 1'b0));
    step(1'b1, 1'b1, 300, -300, -129, 129, 1, 1'b0, 1'b1,
         m_word(300, -300, -129, 129, 1, 1'b0));
    drain();

    // Latency from an empty FIFO with the sink stalled
    step(1'b1, 1'b1, 64, -64, 0, 1, 2, 1'b0, 1'b0, m_word(64, -64, 0, 1, 2, 1'b0));
    chk("lat_k", 64'(o_vld), 64'd0);
    @(posedge clk); #1;
    chk("lat_k1", 64'(o_vld), 64'd0);
    @(posedge clk); #1;
    chk("lat_k2", 64'(o_vld), 64'd1);
    drain();

    // Overflow: six beats into a four-entry FIFO with no pops
    for (int i = 0; i < 6; i++) begin
      step(1'b1, (i < 4), i * 37 - 90, -i * 211, i * 5000, 17 - i, 3, 1'b0, 1'b0,
           m_word(i * 37 - 90, -i * 211, i * 5000, 17 - i, 3, 1'b0));
    end
    idle(3, 1'b0);
    chk("ovf_vld", 64'(o_vld), 64'd1);
    chk("ovf_set", 64'(o_ovf), 64'd1);
    drain();
    chk("ovf_sticky", 64'(o_ovf), 64'd1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(o_ovf), 64'd0);

    // Reset with words queued and an overflow pending
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, i, i, i, i, 0, 1'b0, 1'b0, 32'h0);
    idle(3, 1'b0);
    chk("pre_rst_ovf", 64'(o_ovf), 64'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    fcnt = 0;
    chk("mid_rst_vld", 64'(o_vld), 64'd0);
    chk("mid_rst_ovf", 64'(o_ovf), 64'd0);

    // Frames of three words, sink ready toggling each cycle
    for (int i = 0; i < 14; i++) begin
      int j;
      j = i / 2;
      step((i % 2 == 0), 1'b1, j * 300 - 1000, 500 - j * 97, -j * 4000, j * j, 3, j[0],
           (i % 2 == 1), m_word(j * 300 - 1000, 500 - j * 97, -j * 4000, j * j, 3, j[0]));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
